// File: rtl/filter_pad_sequencer.sv
// Frame sequencer: wraps a raw RGB raster in zero padding and flush pixels
// for the line-buffer filter, with a single registered output stage.
module filter_pad_sequencer #(
  parameter int WIDTH        = 320,
  parameter int HEIGHT       = 240,
  parameter int KERNEL_SIZE  = 3,
  parameter int FLUSH_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic        busy,
  output logic        frame_done,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [23:0] in_data,
  input  logic        out_ready,
  output logic        out_valid,
  output logic [23:0] out_data
);

  localparam int PAD = (KERNEL_SIZE - 1) / 2;
  localparam int PW  = WIDTH + 2 * PAD;
  localparam int PH  = HEIGHT + 2 * PAD;
  localparam int CW  = $clog2(PW + 1);
  localparam int RW  = $clog2(PH + 1);
  localparam int FW  = $clog2(FLUSH_CYCLES + 2);

  localparam logic [CW-1:0] C_LPAD_END = CW'(PAD);
  localparam logic [CW-1:0] C_DATA_END = CW'(PAD + WIDTH);
  localparam logic [CW-1:0] C_ROW_END  = CW'(PW);
  localparam logic [RW-1:0] R_TOP_END  = RW'(PAD);
  localparam logic [RW-1:0] R_DATA_END = RW'(PAD + HEIGHT);
  localparam logic [RW-1:0] R_BOT_END  = RW'(PH);
  localparam logic [FW-1:0] F_END      = FW'(FLUSH_CYCLES);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_TOP   = 3'd1;
  localparam logic [2:0] S_LPAD  = 3'd2;
  localparam logic [2:0] S_DATA  = 3'd3;
  localparam logic [2:0] S_RPAD  = 3'd4;
  localparam logic [2:0] S_BOT   = 3'd5;
  localparam logic [2:0] S_FLUSH = 3'd6;
  localparam logic [2:0] S_DONE  = 3'd7;

  // Degenerate PAD / FLUSH values skip the empty phases entirely.
  localparam logic [2:0] S_FIRST = (PAD > 0) ? S_TOP : S_DATA;
  localparam logic [2:0] S_ROW   = (PAD > 0) ? S_LPAD : S_DATA;
  localparam logic [2:0] S_TAIL  = (FLUSH_CYCLES > 0) ? S_FLUSH : S_DONE;

  logic [2:0]    r_state;
  logic [CW-1:0] r_col;
  logic [RW-1:0] r_row;
  logic [FW-1:0] r_fl;
  logic          r_busy;
  logic          r_frame_done;
  logic          r_out_valid;
  logic [23:0]   r_out_data;

  logic          w_adv;
  logic          w_gen;
  logic [23:0]   w_pix;
  logic [CW-1:0] w_col_nx;
  logic [RW-1:0] w_row_nx;
  logic [FW-1:0] w_fl_nx;
  logic [2:0]    w_row_tgt;
  logic          w_row_state;

  assign w_adv    = !r_out_valid || out_ready;
  assign w_col_nx = r_col + CW'(1);
  assign w_row_nx = r_row + RW'(1);
  assign w_fl_nx  = r_fl + FW'(1);

  assign w_row_state = (r_state == S_TOP) || (r_state == S_LPAD) ||
                       (r_state == S_DATA) || (r_state == S_RPAD) ||
                       (r_state == S_BOT);

  always_comb begin
    w_gen = 1'b0;
    w_pix = 24'h0;
    case (r_state)
      S_TOP, S_LPAD, S_RPAD, S_BOT, S_FLUSH: w_gen = w_adv;
      S_DATA: begin
        w_gen = w_adv && in_valid;
        w_pix = in_data;
      end
      default: w_gen = 1'b0;
    endcase
  end

  // Where the raster goes after the row just completed.
  always_comb begin
    w_row_tgt = S_TAIL;
    if (w_row_nx < R_TOP_END)
      w_row_tgt = S_TOP;
    else if (w_row_nx < R_DATA_END)
      w_row_tgt = S_ROW;
    else if (w_row_nx < R_BOT_END)
      w_row_tgt = S_BOT;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state      <= S_IDLE;
      r_col        <= '0;
      r_row        <= '0;
      r_fl         <= '0;
      r_busy       <= 1'b0;
      r_frame_done <= 1'b0;
      r_out_valid  <= 1'b0;
      r_out_data   <= 24'h0;
    end else begin
      r_frame_done <= 1'b0;
      if (w_adv) begin
        r_out_valid <= w_gen;
        if (w_gen)
          r_out_data <= w_pix;
      end

      if (r_state == S_IDLE) begin
        if (start && !r_frame_done) begin
          r_state <= S_FIRST;
          r_busy  <= 1'b1;
          r_col   <= '0;
          r_row   <= '0;
          r_fl    <= '0;
        end
      end else if (w_row_state) begin
        if (w_gen) begin
          if (w_col_nx == C_ROW_END) begin
            r_col   <= '0;
            r_row   <= (w_row_nx == R_BOT_END) ? '0 : w_row_nx;
            r_state <= w_row_tgt;
          end else begin
            r_col <= w_col_nx;
            if (r_state == S_LPAD && w_col_nx == C_LPAD_END)
              r_state <= S_DATA;
            else if (r_state == S_DATA && w_col_nx == C_DATA_END)
              r_state <= S_RPAD;
          end
        end
      end else if (r_state == S_FLUSH) begin
        if (w_gen) begin
          if (w_fl_nx == F_END) begin
            r_fl    <= '0;
            r_state <= S_DONE;
          end else begin
            r_fl <= w_fl_nx;
          end
        end
      end else begin
        // DONE: last pixel sits in the output register until taken.
        if (r_out_valid && out_ready) begin
          r_frame_done <= 1'b1;
          r_busy       <= 1'b0;
          r_state      <= S_IDLE;
        end
      end
    end
  end

  assign in_ready   = (r_state == S_DATA) && w_adv;
  assign busy       = r_busy;
  assign frame_done = r_frame_done;
  assign out_valid  = r_out_valid;
  assign out_data   = r_out_data;

endmodule

// File: tb/tb_filter_pad_sequencer.sv
// Directed bench for filter_pad_sequencer: two configs (K=3 and K=7),
// backpressure, input gaps, mid-frame reset and ignored starts.
module tb_filter_pad_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, start, in_valid, out_ready, sel;
  logic [23:0] in_data;
  logic        st0, st1;
  logic        busy0, fd0, ir0, ov0;
  logic        busy1, fd1, ir1, ov1;
  logic [23:0] od0, od1;
  logic        busy_m, fd_m, ir_m, ov_m;
  logic [23:0] od_m;

  assign st0 = start && !sel;
  assign st1 = start && sel;

  filter_pad_sequencer #(
    .WIDTH(4), .HEIGHT(3), .KERNEL_SIZE(3), .FLUSH_CYCLES(2)
  ) u_d0 (
    .clk(clk), .reset(reset), .start(st0), .busy(busy0),
    .frame_done(fd0), .in_valid(in_valid), .in_ready(ir0),
    .in_data(in_data), .out_ready(out_ready), .out_valid(ov0),
    .out_data(od0)
  );

  filter_pad_sequencer #(
    .WIDTH(8), .HEIGHT(2), .KERNEL_SIZE(7), .FLUSH_CYCLES(2)
  ) u_d1 (
    .clk(clk), .reset(reset), .start(st1), .busy(busy1),
    .frame_done(fd1), .in_valid(in_valid), .in_ready(ir1),
    .in_data(in_data), .out_ready(out_ready), .out_valid(ov1),
    .out_data(od1)
  );

  assign busy_m = sel ? busy1 : busy0;
  assign fd_m   = sel ? fd1 : fd0;
  assign ir_m   = sel ? ir1 : ir0;
  assign ov_m   = sel ? ov1 : ov0;
  assign od_m   = sel ? od1 : od0;

  int n_tot;
  int n_bad;

  task automatic check(input string tag, input int got, input int exp);
    n_tot++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  function automatic logic [23:0] pix(input int i);
    return {8'(i + 1), 8'h5A, 8'(200 - i)};
  endfunction

  // Reference raster: zero border, data inside, zeros for flush.
  function automatic int expv(input bit s, input int k);
    int w, h, p, pw, ph, r, c;
    w  = s ? 8 : 4;
    h  = s ? 2 : 3;
    p  = s ? 3 : 1;
    pw = w + 2 * p;
    ph = h + 2 * p;
    if (k >= pw * ph) return 0;
    r = k / pw;
    c = k % pw;
    if (r >= p && r < p + h && c >= p && c < p + w)
      return int'(pix((r - p) * w + (c - p)));
    return 0;
  endfunction

  task automatic run_frame(input bit s, input int mode, input int exp_tot);
    int nx, in_idx, cyc, last, fdn, hold_cnt, extra;
    logic [23:0] held;
    bit done;
    nx = 0; in_idx = 0; cyc = 0; last = -10;
    fdn = 0; hold_cnt = 0; extra = 0; done = 0; held = '0;
    sel = s;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    #1 check("busy_on", int'(busy_m), 1);
    while (!done && cyc < 3000) begin
      in_valid  = (mode == 1 || mode == 3) ? (cyc % 2 == 0) : 1'b1;
      out_ready = 1'b1;
      if (mode == 2 && nx >= 9 && hold_cnt < 5) out_ready = 1'b0;
      if (mode == 3 && cyc % 3 == 2) out_ready = 1'b0;
      start   = (mode == 6 && cyc == 12);
      in_data = pix(in_idx);
      #1;
      if (ov_m && !out_ready) begin
        check("rdy_stall", int'(ir_m), 0);
        if (mode == 2) begin
          if (hold_cnt == 0) held = od_m;
          else check("hold", int'(od_m), int'(held));
          hold_cnt++;
        end
      end
      if (in_valid && ir_m) in_idx++;
      if (ov_m && out_ready) begin
        check($sformatf("px%0d", nx), int'(od_m), expv(s, nx));
        nx++;
        if (nx == exp_tot) last = cyc;
      end
      if (fd_m) begin
        fdn++;
        check("fd_lat", cyc - last, 1);
        check("tot", nx, exp_tot);
        check("in_cnt", in_idx, s ? 16 : 12);
        check("busy_off", int'(busy_m), 0);
        if (mode == 6) start = 1'b1;
        done = 1'b1;
      end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    check("timeout", int'(done), 1);
    repeat (6) begin
      #1;
      if (fd_m) extra++;
      if (ov_m) extra++;
      @(negedge clk);
    end
    check("one_fd", fdn + extra, 1);
    check("idle_busy", int'(busy_m), 0);
  endtask

  task automatic run_abort();
    int nx, cyc, bad;
    nx = 0; cyc = 0; bad = 0;
    sel = 1'b0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    while (nx < 9 && cyc < 200) begin
      in_data = pix(nx > 7 ? nx - 7 : 0);
      #1;
      if (ov_m && out_ready) nx++;
      @(negedge clk);
      cyc++;
    end
    check("abort_reach", nx, 9);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("rst_busy", int'(busy_m), 0);
    check("rst_ov", int'(ov_m), 0);
    check("rst_ir", int'(ir_m), 0);
    repeat (10) begin
      #1;
      if (fd_m || busy_m || ov_m) bad++;
      @(negedge clk);
    end
    check("rst_quiet", bad, 0);
  endtask

  initial begin
    n_tot = 0; n_bad = 0;
    reset = 1'b0; start = 1'b0; sel = 1'b0;
    in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
    repeat (3) @(negedge clk);
    #1;
    check("r_busy", int'(busy0), 0);
    check("r_fd", int'(fd0), 0);
    check("r_ir", int'(ir0), 0);
    check("r_ov", int'(ov0), 0);
    check("r_od", int'(od0), 0);
    check("r_ov1", int'(ov1), 0);
    reset = 1'b1;
    run_frame(1'b0, 0, 32);
    run_frame(1'b0, 1, 32);
    run_frame(1'b0, 3, 32);
    run_frame(1'b0, 2, 32);
    run_frame(1'b1, 0, 114);
    run_frame(1'b1, 3, 114);
    run_abort();
    run_frame(1'b0, 0, 32);
    run_frame(1'b0, 6, 32);
    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule
